tdm_demux2: RTL and testbench

//  Receive end of the 2-channel time-division link: splits one serial bitstream back into two
//  W-bit channel words, undoing the 2:1 selection done at the transmit side.

---
 rtl/tdm_demux2_pkg.sv | 14 +
 rtl/tdm_shift_in.sv | 32 +++
 rtl/tdm_demux2.sv | 152 +++++++++++++++
 tb/tb_tdm_demux2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux2_pkg.sv
// Shared definitions for the 2-channel TDM link: state encodings and default word width.
// The transmit-side block uses the same encodings.
package tdm_demux2_pkg;

  localparam int TDM_W = 8;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_CH0  = 2'd1,
    ST_CH1  = 2'd2,
    ST_BAD  = 2'd3
  } tdm_state_t;

endpackage

// File: rtl/tdm_shift_in.sv
// Serial-in, MSB-first word assembler with enable and restart.
// Only W-1 bits are stored: the final bit of a word goes straight from i_din into o_word.
module tdm_shift_in #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_din,
  output logic [W-1:0] o_word
);

  localparam int SW = W - 1;

  logic [SW-1:0] r_sr;
  logic [W-1:0]  w_shifted;

  assign w_shifted = {r_sr, i_din};
  assign o_word    = w_shifted;

  // A restart slot begins a fresh word with the current bit as its MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_en) begin
      if (i_clr) r_sr <= SW'(i_din);
      else       r_sr <= w_shifted[SW-1:0];
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Receive side of the 2-channel TDM link: tracks frame position from fsync and delivers
// the ch0/ch1 words with one-cycle valid pulses, a lock flag and a framing-error pulse.
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int W = TDM_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_bit_en,
  input  logic         i_din,
  input  logic         i_fsync,
  output logic [W-1:0] o_ch0_data,
  output logic         o_ch0_valid,
  output logic [W-1:0] o_ch1_data,
  output logic         o_ch1_valid,
  output logic         o_locked,
  output logic         o_sync_err
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tdm_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_ch0_data, r_ch1_data;
  logic             r_ch0_valid, r_ch1_valid, r_locked, r_sync_err;

  logic             w_sh_en, w_sh_clr;
  logic             w_ld_ch0, w_ld_ch1, w_lock_set, w_lock_clr, w_err;
  logic [W-1:0]     w_word;

  tdm_shift_in #(.W(W)) u_shift (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_sh_en),
    .i_clr   (w_sh_clr),
    .i_din   (i_din),
    .o_word  (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_en     = 1'b0;
    w_sh_clr    = 1'b0;
    w_ld_ch0    = 1'b0;
    w_ld_ch1    = 1'b0;
    w_lock_set  = 1'b0;
    w_lock_clr  = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (i_bit_en && i_fsync) begin
          w_sh_en     = 1'b1;
          w_sh_clr    = 1'b1;
          w_cnt_nxt   = CNT_ONE;
          w_state_nxt = ST_CH0;
        end
      end
      ST_CH0: begin
        // cnt==0 in CH0 is the expected frame start: fsync is mandatory there, illegal elsewhere.
        if (i_bit_en) begin
          if (r_cnt == '0) begin
            if (i_fsync) begin
              w_sh_en   = 1'b1;
              w_sh_clr  = 1'b1;
              w_cnt_nxt = CNT_ONE;
            end else begin
              w_err       = 1'b1;
              w_lock_clr  = 1'b1;
              w_state_nxt = ST_HUNT;
            end
          end else if (i_fsync) begin
            w_err      = 1'b1;
            w_lock_clr = 1'b1;
            w_sh_en    = 1'b1;
            w_sh_clr   = 1'b1;
            w_cnt_nxt  = CNT_ONE;
          end else begin
            w_sh_en = 1'b1;
            if (r_cnt == CNT_LAST) begin
              w_ld_ch0    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_CH1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
      end
      ST_CH1: begin
        if (i_bit_en) begin
          if (i_fsync) begin
            w_err       = 1'b1;
            w_lock_clr  = 1'b1;
            w_sh_en     = 1'b1;
            w_sh_clr    = 1'b1;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ST_CH0;
          end else begin
            w_sh_en = 1'b1;
            if (r_cnt == CNT_LAST) begin
              w_ld_ch1    = 1'b1;
              w_lock_set  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_CH0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_HUNT;
      r_cnt       <= '0;
      r_ch0_data  <= '0;
      r_ch1_data  <= '0;
      r_ch0_valid <= 1'b0;
      r_ch1_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ch0_valid <= w_ld_ch0;
      r_ch1_valid <= w_ld_ch1;
      r_sync_err  <= w_err;
      if (w_ld_ch0) r_ch0_data <= w_word;
      if (w_ld_ch1) r_ch1_data <= w_word;
      if (w_lock_clr)      r_locked <= 1'b0;
      else if (w_lock_set) r_locked <= 1'b1;
    end
  end

  assign o_ch0_data  = r_ch0_data;
  assign o_ch0_valid = r_ch0_valid;
  assign o_ch1_data  = r_ch1_data;
  assign o_ch1_valid = r_ch1_valid;
  assign o_locked    = r_locked;
  assign o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2: a frame-position reference model queues expected events,
// and a monitor pops and compares them whenever the DUT pulses valid or sync_err.
module tb_tdm_demux2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstN;
  logic         bitEn;
  logic         din;
  logic         fsync;
  logic [W-1:0] ch0Data, ch1Data;
  logic         ch0Valid, ch1Valid, locked, syncErr;

  tdm_demux2 #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_bit_en    (bitEn),
    .i_din       (din),
    .i_fsync     (fsync),
    .o_ch0_data  (ch0Data),
    .o_ch0_valid (ch0Valid),
    .o_ch1_data  (ch1Data),
    .o_ch1_valid (ch1Valid),
    .o_locked    (locked),
    .o_sync_err  (syncErr)
  );

  always #5 clk = ~clk;

  // kind: 0 = ch0 word, 1 = ch1 word, 2 = sync error
  typedef struct {
    int kind;
    int data;
    int lockedExp;
  } expEvent_t;

  expEvent_t expQ[$];
  int nChecks = 0;
  int nPass   = 0;

  // Model: position within the 2W-slot frame, -1 while hunting for fsync.
  int modelPos    = -1;
  int modelAcc    = 0;
  int modelLocked = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic modelSlot(input logic d, input logic fs);
    if (modelPos < 0) begin
      if (fs) begin
        modelPos = 1;
        modelAcc = int'(d);
      end
    end else if (fs && modelPos != 0) begin
      expQ.push_back('{2, 0, 0});
      modelLocked = 0;
      modelPos    = 1;
      modelAcc    = int'(d);
    end else if (!fs && modelPos == 0) begin
      expQ.push_back('{2, 0, 0});
      modelLocked = 0;
      modelPos    = -1;
    end else begin
      if (modelPos == 0) modelAcc = 0;
      modelAcc = modelAcc * 2 + int'(d);
      modelPos++;
      if (modelPos == W) begin
        expQ.push_back('{0, modelAcc, modelLocked});
        modelAcc = 0;
      end else if (modelPos == 2 * W) begin
        modelLocked = 1;
        expQ.push_back('{1, modelAcc, 1});
        modelAcc = 0;
        modelPos = 0;
      end
    end
  endtask

  // One slot: optional idle cycles, then one cycle with bitEn high; gap<0 picks 0..2 at random.
  task automatic applyStimulus(input logic d, input logic fs, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) begin
      @(posedge clk); #1;
      bitEn = 1'b0; fsync = 1'b0; din = 1'($urandom);
    end
    @(posedge clk); #1;
    bitEn = 1'b1; din = d; fsync = fs;
    modelSlot(d, fs);
  endtask

  task automatic sendWord(input logic [W-1:0] v, input int nBits, input logic firstFs, input int gap);
    for (int i = 0; i < nBits; i++)
      applyStimulus(v[W-1-i], (i == 0) ? firstFs : 1'b0, gap);
  endtask

  task automatic sendFrame(input logic [W-1:0] a, input logic [W-1:0] b, input logic fs, input int gap);
    sendWord(a, W, fs, gap);
    sendWord(b, W, 1'b0, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bitEn = 1'b0; fsync = 1'b0; din = 1'b0;
    end
  endtask

  // Reset is dropped mid-cycle so its effect is visible without any clock edge.
  task automatic doReset();
    idle(1);
    @(negedge clk); #1;
    rstN = 1'b0;
    #1;
    checkOutput("rstCh0Data",  int'(ch0Data),  0);
    checkOutput("rstCh1Data",  int'(ch1Data),  0);
    checkOutput("rstCh0Valid", int'(ch0Valid), 0);
    checkOutput("rstCh1Valid", int'(ch1Valid), 0);
    checkOutput("rstLocked",   int'(locked),   0);
    checkOutput("rstSyncErr",  int'(syncErr),  0);
    checkOutput("rstPending",  expQ.size(),    0);
    expQ.delete();
    modelPos    = -1;
    modelAcc    = 0;
    modelLocked = 0;
    @(negedge clk); #1;
    rstN = 1'b1;
    idle(2);
  endtask

  int        monKind;
  expEvent_t monEv;

  always @(negedge clk) begin
    if (rstN && (ch0Valid || ch1Valid || syncErr)) begin
      checkOutput("singlePulse", int'(ch0Valid) + int'(ch1Valid) + int'(syncErr), 1);
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpectedEvent actual=v0:%0d v1:%0d err:%0d required=no event",
                 ch0Valid, ch1Valid, syncErr);
      end else begin
        monEv   = expQ.pop_front();
        monKind = syncErr ? 2 : (ch1Valid ? 1 : 0);
        checkOutput("eventKind", monKind, monEv.kind);
        if (monEv.kind == 0)      checkOutput("ch0Data", int'(ch0Data), monEv.data);
        else if (monEv.kind == 1) checkOutput("ch1Data", int'(ch1Data), monEv.data);
        checkOutput("lockedAtEvent", int'(locked), monEv.lockedExp);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int waitCycles;
    logic [W-1:0] a, b;
    rstN = 1'b0; bitEn = 1'b0; din = 1'b0; fsync = 1'b0;
    idle(2);

    doReset();
    idle(20);
    checkOutput("idleLocked",  int'(locked),  0);
    checkOutput("idleCh0Data", int'(ch0Data), 0);

    sendFrame(8'hA5, 8'h3C, 1'b1, 0);
    idle(3);
    checkOutput("lockedAfterA5", int'(locked), 1);

    sendFrame(8'h12, 8'h34, 1'b1, 2);
    sendFrame(8'h56, 8'h78, 1'b1, 2);
    idle(3);
    checkOutput("lockedAfterGaps", int'(locked), 1);

    sendFrame(8'h9A, 8'hBC, 1'b0, 0);
    idle(3);
    checkOutput("lockedAfterMiss", int'(locked), 0);
    sendFrame(8'hDE, 8'hF0, 1'b1, 0);
    idle(3);

    sendWord(8'h11, W, 1'b1, 0);
    sendWord(8'h22, 4, 1'b0, 0);
    sendFrame(8'hFF, 8'h00, 1'b1, 0);
    idle(3);
    checkOutput("resyncCh0", int'(ch0Data), 8'hFF);
    checkOutput("resyncCh1", int'(ch1Data), 8'h00);
    checkOutput("resyncLocked", int'(locked), 1);

    sendWord(8'h6B, 5, 1'b1, 0);
    doReset();
    sendFrame(8'h81, 8'h18, 1'b1, 0);
    idle(3);
    checkOutput("postRstCh0", int'(ch0Data), 8'h81);
    checkOutput("postRstCh1", int'(ch1Data), 8'h18);

    for (int f = 0; f < 40; f++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        sendFrame(a, b, 1'b0, -1);
      end else if (r == 1) begin
        sendWord(a, W, 1'b1, -1);
        sendWord(b, int'($urandom_range(0, W - 1)), 1'b0, -1);
      end else if (r == 2) begin
        sendWord(a, int'($urandom_range(1, W - 1)), 1'b1, -1);
      end else begin
        sendFrame(a, b, 1'b1, -1);
      end
    end
    idle(1);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    idle(2);
    checkOutput("queueDrained", expQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
